// File: rtl/spmmio_pkg.sv
// Shared types and constants for the special-purpose MMIO bus arbiter.
// Buses are big-endian numbered: bit 0 is the most significant.
package spmmio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int ADR_W   = 24;
    localparam int DAT_W   = 32;
    localparam int SEL_W   = 4;
    localparam int ADR_LSB = 21;

    typedef logic [0:ADR_W-1] adr_t;
    typedef logic [0:DAT_W-1] dat_t;
    typedef logic [0:SEL_W-1] sel_t;

    typedef struct packed {
        adr_t adr;
        logic stb;
        logic cyc;
        sel_t sel;
        logic we;
        dat_t dat;
    } mreq_t;

    // Selects the request of the owning master, or an all-zero request when nobody owns the bus.
    function automatic mreq_t pick_req(input logic owned, input logic owner,
                                       input mreq_t r0, input mreq_t r1);
        if (!owned)
            return '0;
        return owner ? r1 : r0;
    endfunction

endpackage

// File: rtl/spmmio_arbiter.sv
// Round-robin two-master arbiter for the MMIO slave bus with bus locking via cyc
// and a strobe watchdog that ends unacknowledged accesses with a one-cycle err.
module spmmio_arbiter
    import spmmio_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [0:23]       m0_adr_i,
    input  logic              m0_stb_i,
    input  logic              m0_cyc_i,
    input  logic [0:3]        m0_sel_i,
    input  logic              m0_we_i,
    input  logic [0:31]       m0_dat_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [0:31]       m0_dat_o,

    input  logic [0:23]       m1_adr_i,
    input  logic              m1_stb_i,
    input  logic              m1_cyc_i,
    input  logic [0:3]        m1_sel_i,
    input  logic              m1_we_i,
    input  logic [0:31]       m1_dat_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [0:31]       m1_dat_o,

    output logic [0:23]       s_adr_o,
    output logic              s_stb_o,
    output logic              s_cyc_o,
    output logic [0:3]        s_sel_o,
    output logic              s_we_o,
    output logic [0:31]       s_dat_o,
    input  logic              s_ack_i,
    input  logic [0:31]       s_dat_i,

    output arb_state_e        dbg_state,
    output logic              dbg_last,
    output logic [CW-1:0]     dbg_wdog
);

    arb_state_e    state_q, state_d;
    logic          last_q;
    logic [CW-1:0] wdog_q;

    logic  owned, owner, tmo, ack;
    logic  own0, own1;
    mreq_t r0, r1, cur;

    assign r0 = '{adr: m0_adr_i, stb: m0_stb_i, cyc: m0_cyc_i,
                  sel: m0_sel_i, we: m0_we_i, dat: m0_dat_i};
    assign r1 = '{adr: m1_adr_i, stb: m1_stb_i, cyc: m1_cyc_i,
                  sel: m1_sel_i, we: m1_we_i, dat: m1_dat_i};

    always_comb begin
        state_d = state_q;
        owned   = 1'b0;
        owner   = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_d = last_q ? OWN0 : OWN1;
                else if (m0_cyc_i)
                    state_d = OWN0;
                else if (m1_cyc_i)
                    state_d = OWN1;
            end
            OWN0: begin
                owned = 1'b1;
                owner = 1'b0;
                // Owner releasing while the other master waits hands over without an IDLE gap.
                if (!m0_cyc_i)
                    state_d = m1_cyc_i ? OWN1 : IDLE;
            end
            OWN1: begin
                owned = 1'b1;
                owner = 1'b1;
                if (!m1_cyc_i)
                    state_d = m0_cyc_i ? OWN0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_d == OWN0 && state_q != OWN0)
                last_q <= 1'b0;
            else if (state_d == OWN1 && state_q != OWN1)
                last_q <= 1'b1;
        end
    end

    assign tmo = (TIMEOUT != 0) && (wdog_q == CW'(TIMEOUT));

    // The counter only runs while a strobe is outstanding, so it is always zero on ownership changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdog_q <= '0;
        else if (!s_stb_o || s_ack_i || tmo)
            wdog_q <= '0;
        else
            wdog_q <= wdog_q + CW'(1);
    end

    assign cur = pick_req(owned, owner, r0, r1);

    assign s_adr_o = cur.adr;
    assign s_sel_o = cur.sel;
    assign s_we_o  = cur.we;
    assign s_dat_o = cur.dat;
    assign s_cyc_o = cur.cyc;
    assign s_stb_o = cur.stb & cur.cyc & ~tmo;

    assign ack  = s_ack_i & s_stb_o;
    assign own0 = owned & ~owner;
    assign own1 = owned & owner;

    assign m0_ack_o = own0 & ack;
    assign m0_err_o = own0 & tmo;
    assign m0_dat_o = own0 ? s_dat_i : '0;
    assign m1_ack_o = own1 & ack;
    assign m1_err_o = own1 & tmo;
    assign m1_dat_o = own1 ? s_dat_i : '0;

    assign dbg_state = state_q;
    assign dbg_last  = last_q;
    assign dbg_wdog  = wdog_q;

endmodule

// File: tb/tb_spmmio_arbiter.sv
// Directed bench for spmmio_arbiter: responses expected by each master are queued
// when stimulus is issued and matched by a monitor whenever the DUT returns ack/err.
module tb_spmmio_arbiter;
    import spmmio_pkg::*;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 8;

    logic        clk, reset;
    logic [0:23] m0_adr_i, m1_adr_i, s_adr_o;
    logic        m0_stb_i, m0_cyc_i, m0_we_i, m1_stb_i, m1_cyc_i, m1_we_i;
    logic [0:3]  m0_sel_i, m1_sel_i, s_sel_o;
    logic [0:31] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_stb_o, s_cyc_o, s_we_o, s_ack_i;
    arb_state_e  dbg_state;
    logic        dbg_last;
    logic [CW-1:0] dbg_wdog;

    logic        slave_en;
    logic [31:0] slave_dat;

    // Expected master response: {master, err, read data}
    logic [33:0] exp_q[$];
    int vectors = 0;
    int errors  = 0;

    logic [23:0] t3_adr[4] = '{24'h000100, 24'h000104, 24'h000108, 24'h00010C};
    logic [3:0]  t3_sel[4] = '{4'hF, 4'h1, 4'h8, 4'h6};
    logic [31:0] t3_wd[4]  = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hC3C3_0003, 32'h3C3C_0004};
    logic [31:0] t3_rd[4]  = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000};

    spmmio_arbiter #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_dat_o(m0_dat_o),
        .m1_adr_i(m1_adr_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_dat_o(m1_dat_o),
        .s_adr_o(s_adr_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
        .dbg_state(dbg_state), .dbg_last(dbg_last), .dbg_wdog(dbg_wdog)
    );

    // Slave model: combinational ack when enabled, fixed read data.
    assign s_ack_i = s_stb_o & slave_en;
    assign s_dat_i = slave_dat;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return |{s_adr_o, s_stb_o, s_cyc_o, s_sel_o, s_we_o, s_dat_o,
                 m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        m0_adr_i = '0; m0_stb_i = 0; m0_cyc_i = 0; m0_sel_i = '0; m0_we_i = 0; m0_dat_i = '0;
        m1_adr_i = '0; m1_stb_i = 0; m1_cyc_i = 0; m1_sel_i = '0; m1_we_i = 0; m1_dat_i = '0;
        slave_en = 0; slave_dat = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [33:0] act, exp;
        if (!reset && (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o)) begin
            if (m0_ack_o || m0_err_o)
                act = {1'b0, m0_err_o, m0_dat_o};
            else
                act = {1'b1, m1_err_o, m1_dat_o};
            check("ack_err_exclusive", {62'd0, m0_ack_o | m1_ack_o, m0_err_o | m1_err_o} == 64'd3, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_response", {30'd0, act}, 64'd0);
            end else begin
                exp = exp_q.pop_front();
                check("response", {30'd0, act}, {30'd0, exp});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        check("rst_outputs_zero", any_out(), 0);
        check("rst_state", dbg_state, IDLE);
        check("rst_last", dbg_last, 1);
        check("rst_wdog", dbg_wdog, 0);
        do_reset();

        // 1: single m0 read, combinational ack
        next_cycle();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000004; m0_sel_i = 4'hF;
        slave_en = 1; slave_dat = 32'hDEADBEEF;
        exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
        @(negedge clk);
        check("t1_no_stb_in_idle", s_stb_o, 0);
        next_cycle();
        @(negedge clk);
        check("t1_stb", s_stb_o, 1);
        check("t1_adr", s_adr_o, 24'h000004);
        check("t1_m1_quiet", {m1_ack_o, m1_err_o, m1_dat_o}, 0);
        next_cycle();
        m0_cyc_i = 0; m0_stb_i = 0;
        next_cycle();
        @(negedge clk);
        check("t1_back_idle", dbg_state, IDLE);

        // 2: simultaneous requests, round-robin and gapless handover
        do_reset();
        next_cycle();
        m0_cyc_i = 1; m1_cyc_i = 1; slave_en = 1;
        next_cycle();
        @(negedge clk);
        check("t2_first_grant", dbg_state, OWN0);
        next_cycle();
        m0_stb_i = 1; m0_adr_i = 24'h000020; slave_dat = 32'h11111111;
        exp_q.push_back({1'b0, 1'b0, 32'h11111111});
        next_cycle();
        m0_cyc_i = 0; m0_stb_i = 0;
        @(negedge clk);
        check("t2_m1_not_yet", m1_ack_o, 0);
        next_cycle();
        @(negedge clk);
        check("t2_handover", dbg_state, OWN1);
        check("t2_cyc", s_cyc_o, 1);
        check("t2_last", dbg_last, 1);
        next_cycle();
        m1_stb_i = 1; m1_adr_i = 24'h000040; slave_dat = 32'h22222222;
        exp_q.push_back({1'b1, 1'b0, 32'h22222222});
        next_cycle();
        m1_cyc_i = 0; m1_stb_i = 0;
        next_cycle();
        m0_cyc_i = 1; m1_cyc_i = 1;
        @(negedge clk);
        check("t2_idle_between", dbg_state, IDLE);
        next_cycle();
        @(negedge clk);
        check("t2_second_tie", dbg_state, OWN0);
        check("t2_last_after", dbg_last, 0);
        m0_cyc_i = 0; m1_cyc_i = 0;
        next_cycle();
        next_cycle();

        // 3: m1 locks the bus for four strobes while m0 waits
        m1_cyc_i = 1; slave_en = 1;
        next_cycle();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000010;
        for (int k = 0; k < 4; k++) begin
            m1_stb_i = 1; m1_we_i = 1; m1_adr_i = t3_adr[k]; m1_sel_i = t3_sel[k];
            m1_dat_i = t3_wd[k]; slave_dat = t3_rd[k];
            exp_q.push_back({1'b1, 1'b0, t3_rd[k]});
            @(negedge clk);
            check("t3_adr", s_adr_o, t3_adr[k]);
            check("t3_sel", s_sel_o, t3_sel[k]);
            check("t3_dat", s_dat_o, t3_wd[k]);
            check("t3_we", s_we_o, 1);
            check("t3_m0_waits", m0_ack_o, 0);
            next_cycle();
        end
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        @(negedge clk);
        check("t3_m0_waits_release", m0_ack_o, 0);
        next_cycle();
        slave_dat = 32'h33333333;
        exp_q.push_back({1'b0, 1'b0, 32'h33333333});
        @(negedge clk);
        check("t3_m0_granted", dbg_state, OWN0);
        check("t3_m0_adr", s_adr_o, 24'h000010);
        next_cycle();
        m0_cyc_i = 0; m0_stb_i = 0;
        next_cycle();

        // 4: watchdog with a slave that never acks
        slave_en = 0; slave_dat = 32'hBAD0BAD0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000200;
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_stb_held", s_stb_o, 1);
            check("t4_no_err", m0_err_o, 0);
            next_cycle();
        end
        exp_q.push_back({1'b0, 1'b1, 32'hBAD0BAD0});
        @(negedge clk);
        check("t4_tmo_stb_low", s_stb_o, 0);
        check("t4_tmo_wdog", dbg_wdog, TIMEOUT);
        next_cycle();
        m0_stb_i = 0;
        @(negedge clk);
        check("t4_wdog_cleared", dbg_wdog, 0);
        check("t4_still_owned", dbg_state, OWN0);
        check("t4_err_single", m0_err_o, 0);
        next_cycle();
        m0_cyc_i = 0;
        next_cycle();

        // 5: asynchronous reset in the middle of an m1 strobe
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h000300; slave_dat = 32'h44444444;
        next_cycle();
        @(negedge clk);
        check("t5_owned", dbg_state, OWN1);
        check("t5_stb", s_stb_o, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_zero", any_out(), 0);
        check("t5_async_state", dbg_state, IDLE);
        m1_cyc_i = 0; m1_stb_i = 0;
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        check("t5_state_after", dbg_state, IDLE);
        check("t5_last_after", dbg_last, 1);
        check("t5_outputs_after", any_out(), 0);

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
